esfa_op_dispatcher: RTL and testbench
=====================================

Name: esfa_op_dispatcher

Overview:
Command front-end sitting directly upstream of the ESFA operation chooser. Buffers host commands in a small FIFO and decodes each opcode into one or two chooser operations; a lookup is issued as a scan followed by a finalize. Drives the chooser's selector and operand inputs, waits for its completion, and returns a status-tagged response to the host over a valid/ready channel.

Parameters:
DATA_W, 8, width of value and handle fields
IDX_W, 4, width of cell index
FIFO_DEPTH, 4, command buffer entries (power of 2, >=2)
OP_TIMEOUT, 16, max cycles to wait for op_done per chooser operation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_op  in  3  0 LOOKUP, 1 UPDATE, 2 DELETE, 3 ENCODE, 4 CONG_UP, 5 CONG_DOWN, 6-7 illegal
cmd_index  in  IDX_W  target cell index
cmd_value  in  DATA_W  value operand
cmd_handle  in  DATA_W  handle operand
cmd_is_handle  in  1  operand is a handle
op_start  out  1  one-cycle pulse launching a chooser operation
op_selector  out  3  0 SCAN, 1 FINALIZE, 2 UPDATE, 3 DELETE, 4 ENCODE, 5 CONG_UP, 6 CONG_DOWN
op_index  out  IDX_W  to chooser new_index
op_value  out  DATA_W  to chooser new_value
op_handle  out  DATA_W  to chooser new_handle
op_a_is_handle  out  1  to chooser a_isHandle
op_done  in  1  chooser completion pulse
op_result_bool  in  1  chooser resultBool, valid with op_done
op_result_value  in  DATA_W  chooser resultValue, valid with op_done
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_status  out  2  00 OK, 01 ILLEGAL_OP, 10 TIMEOUT
rsp_bool  out  1  result flag
rsp_value  out  DATA_W  result value

Behaviour:
- Reset: FIFO emptied, FSM to IDLE, timer 0; outputs op_start=0, op_selector=0, op_index/op_value/op_handle/op_a_is_handle=0, rsp_valid=0, rsp_status=00, rsp_bool=0, rsp_value=0; cmd_ready=1 from the first cycle after reset. Reset mid-operation abandons the command; no response is produced, and any op_done arriving later is ignored.
- FIFO: push on cmd_valid&cmd_ready; cmd_ready = !full. Simultaneous push and pop on a full FIFO is not allowed; cmd_ready stays 0 when full. Pointers wrap mod FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP.
- IDLE: if FIFO is not empty, pop the head into the command register and go to ISSUE. If the opcode is 6 or 7, go directly to RESP with status 01, bool 0, value 0, and issue no op_start.
- ISSUE: assert op_start for exactly 1 cycle. Operand outputs hold the command fields from ISSUE until the FSM leaves WAIT/WAIT2. Selector is SCAN for LOOKUP, otherwise opcode+1. Clear the timer and go to WAIT.
- WAIT: the timer increments each cycle.
  - op_done with LOOKUP goes to ISSUE2.
  - op_done with any other opcode captures result_bool/result_value and goes to RESP with status 00.
  - If the timer reaches OP_TIMEOUT with no op_done, go to RESP with status 10, bool 0, value 0.
  - op_done in the same cycle as the timeout counts as done.
- ISSUE2/WAIT2: identical to ISSUE/WAIT with selector FINALIZE. The scan result is discarded; the finalize result is returned. The timeout applies independently to each phase.
- op_done outside WAIT/WAIT2 is ignored.
- RESP: rsp_valid=1 with stable fields until rsp_valid&rsp_ready, then return to IDLE. Minimum latency from FIFO head to the next command's op_start is 1 idle cycle.
- Command acceptance continues in every state while the FIFO is not full.
- Throughput: one command in flight downstream at a time, with no overlap of chooser operations.

Test Plan:
- UPDATE idx=3 val=0x5A is pushed; op_done arrives 2 cycles after op_start with value 0x5A -> one op_start, selector=2, op_index=3, op_value=0x5A; rsp status=00, value=0x5A.
- LOOKUP idx=7, with the scan done returning 0x11 and the finalize done returning bool=1 value=0x42 -> two op_start pulses, selector 0 then 1; single rsp status=00 bool=1 value=0x42.
- cmd_op=6 -> no op_start; rsp status=01, value=0; the next queued ENCODE still executes normally.
- DELETE with op_done never asserted -> rsp status=10 exactly OP_TIMEOUT cycles after WAIT entry; FSM returns to IDLE.
- Push 5 commands back-to-back with the chooser stalled, FIFO_DEPTH=4 -> cmd_ready drops after the 4th entry is pending. All commands complete in order and rsp_value matches the issue order.
- rst asserted during WAIT2, then op_done pulsed -> all outputs take reset values, FIFO is empty, and no rsp_valid is produced.

Source files
------------

// File: rtl/esfa_op_dispatcher.sv
// ESFA operation dispatcher: buffers host commands in a small FIFO and sequences
// each one onto the operation chooser, returning a status-tagged response.
module esfa_op_dispatcher #(
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int OP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_index,
  input  logic [DATA_W-1:0] cmd_value,
  input  logic [DATA_W-1:0] cmd_handle,
  input  logic              cmd_is_handle,
  output logic              op_start,
  output logic [2:0]        op_selector,
  output logic [IDX_W-1:0]  op_index,
  output logic [DATA_W-1:0] op_value,
  output logic [DATA_W-1:0] op_handle,
  output logic              op_a_is_handle,
  input  logic              op_done,
  input  logic              op_result_bool,
  input  logic [DATA_W-1:0] op_result_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic              rsp_bool,
  output logic [DATA_W-1:0] rsp_value
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(OP_TIMEOUT + 1);
  localparam int ENT_W = 3 + IDX_W + 2 * DATA_W + 1;

  localparam logic [2:0] SEL_SCAN     = 3'd0;
  localparam logic [2:0] SEL_FINALIZE = 3'd1;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_ILLEGAL   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ISSUE2, S_WAIT2, S_RESP} state_t;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, fifo_empty, fifo_full;

  logic [2:0]        head_op;
  logic [IDX_W-1:0]  head_index;
  logic [DATA_W-1:0] head_value, head_handle;
  logic              head_is_handle;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              lookup_q, lookup_d;
  logic              op_start_q, op_start_d;
  logic [2:0]        op_selector_q, op_selector_d;
  logic [IDX_W-1:0]  op_index_q, op_index_d;
  logic [DATA_W-1:0] op_value_q, op_value_d, op_handle_q, op_handle_d;
  logic              op_a_is_handle_q, op_a_is_handle_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_bool_q, rsp_bool_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0] rsp_value_q, rsp_value_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign {head_op, head_index, head_value, head_handle, head_is_handle} = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_op, cmd_index, cmd_value, cmd_handle, cmd_is_handle};
  end

  always_comb begin
    wr_ptr_d         = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    pop              = 1'b0;
    state_d          = state_q;
    timer_d          = timer_q;
    lookup_d         = lookup_q;
    op_start_d       = 1'b0;
    op_selector_d    = op_selector_q;
    op_index_d       = op_index_q;
    op_value_d       = op_value_q;
    op_handle_d      = op_handle_q;
    op_a_is_handle_d = op_a_is_handle_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_status_d     = rsp_status_q;
    rsp_bool_d       = rsp_bool_q;
    rsp_value_d      = rsp_value_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_op[2:1] == 2'b11) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_ILLEGAL;
            rsp_bool_d   = 1'b0;
            rsp_value_d  = '0;
          end else begin
            state_d          = S_ISSUE;
            op_start_d       = 1'b1;
            lookup_d         = (head_op == 3'd0);
            op_selector_d    = (head_op == 3'd0) ? SEL_SCAN : head_op + 3'd1;
            op_index_d       = head_index;
            op_value_d       = head_value;
            op_handle_d      = head_handle;
            op_a_is_handle_d = head_is_handle;
          end
        end
      end
      S_ISSUE, S_ISSUE2: begin
        timer_d = '0;
        state_d = (state_q == S_ISSUE) ? S_WAIT : S_WAIT2;
      end
      S_WAIT, S_WAIT2: begin
        timer_d = timer_q + TMR_W'(1);
        // A completion in the timeout cycle still counts as a completion.
        if (op_done) begin
          if (state_q == S_WAIT && lookup_q) begin
            state_d       = S_ISSUE2;
            op_start_d    = 1'b1;
            op_selector_d = SEL_FINALIZE;
          end else begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            rsp_bool_d   = op_result_bool;
            rsp_value_d  = op_result_value;
          end
        end else if (timer_q == TMR_W'(OP_TIMEOUT - 1)) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_bool_d   = 1'b0;
          rsp_value_d  = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;
      state_q <= S_IDLE;  timer_q <= '0;  lookup_q <= 1'b0;
      op_start_q <= 1'b0;  op_selector_q <= '0;  op_index_q <= '0;
      op_value_q <= '0;  op_handle_q <= '0;  op_a_is_handle_q <= 1'b0;
      rsp_valid_q <= 1'b0;  rsp_status_q <= ST_OK;  rsp_bool_q <= 1'b0;  rsp_value_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
      state_q <= state_d;  timer_q <= timer_d;  lookup_q <= lookup_d;
      op_start_q <= op_start_d;  op_selector_q <= op_selector_d;  op_index_q <= op_index_d;
      op_value_q <= op_value_d;  op_handle_q <= op_handle_d;  op_a_is_handle_q <= op_a_is_handle_d;
      rsp_valid_q <= rsp_valid_d;  rsp_status_q <= rsp_status_d;
      rsp_bool_q <= rsp_bool_d;  rsp_value_q <= rsp_value_d;
    end
  end

  assign op_start       = op_start_q;
  assign op_selector    = op_selector_q;
  assign op_index       = op_index_q;
  assign op_value       = op_value_q;
  assign op_handle      = op_handle_q;
  assign op_a_is_handle = op_a_is_handle_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_status     = rsp_status_q;
  assign rsp_bool       = rsp_bool_q;
  assign rsp_value      = rsp_value_q;
endmodule

// File: tb/tb_esfa_op_dispatcher.sv
// Directed bench for esfa_op_dispatcher with a small behavioural chooser that
// answers each op_start after a programmable delay.
module tb_esfa_op_dispatcher;
  localparam int DATA_W = 8, IDX_W = 4, FIFO_DEPTH = 4, OP_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, cmd_is_handle;
  logic [2:0] cmd_op;
  logic [IDX_W-1:0] cmd_index;
  logic [DATA_W-1:0] cmd_value, cmd_handle;
  logic op_start, op_a_is_handle, op_done, op_result_bool;
  logic [2:0] op_selector;
  logic [IDX_W-1:0] op_index;
  logic [DATA_W-1:0] op_value, op_handle, op_result_value;
  logic rsp_valid, rsp_ready, rsp_bool;
  logic [1:0] rsp_status;
  logic [DATA_W-1:0] rsp_value;

  int checks = 0, errors = 0;

  // chooser model state: results queued by the stimulus, consumed per op_start
  logic [8:0] res_tab [64];
  int res_wr = 0, res_rd = 0;
  int done_delay = 2;
  bit chooser_en = 1'b1;
  bit manual_done = 1'b0;
  logic [8:0] manual_res = 9'h0;
  int pend_cnt = 0;
  logic [8:0] pend = 9'h0;
  int starts = 0;
  logic [2:0] sel_log[$];
  logic [IDX_W-1:0] idx_log[$];
  logic [DATA_W-1:0] val_log[$], hnd_log[$];
  logic ish_log[$];

  always #5 clk = ~clk;

  esfa_op_dispatcher #(.DATA_W(DATA_W), .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH),
                       .OP_TIMEOUT(OP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_index(cmd_index),
    .cmd_value(cmd_value), .cmd_handle(cmd_handle), .cmd_is_handle(cmd_is_handle),
    .op_start(op_start), .op_selector(op_selector), .op_index(op_index), .op_value(op_value),
    .op_handle(op_handle), .op_a_is_handle(op_a_is_handle),
    .op_done(op_done), .op_result_bool(op_result_bool), .op_result_value(op_result_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_bool(rsp_bool), .rsp_value(rsp_value)
  );

  always @(negedge clk) begin
    op_done         = manual_done;
    op_result_bool  = manual_done ? manual_res[8] : 1'b0;
    op_result_value = manual_done ? manual_res[7:0] : 8'h00;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        op_done         = 1'b1;
        op_result_bool  = pend[8];
        op_result_value = pend[7:0];
      end
    end
    if (op_start === 1'b1) begin
      starts = starts + 1;
      sel_log.push_back(op_selector);
      idx_log.push_back(op_index);
      val_log.push_back(op_value);
      hnd_log.push_back(op_handle);
      ish_log.push_back(op_a_is_handle);
      if (chooser_en) begin
        pend = (res_rd < res_wr) ? res_tab[res_rd] : 9'h0;
        res_rd = res_rd + 1;
        pend_cnt = done_delay;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [IDX_W-1:0] idx,
                          input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] hnd,
                          input logic ish);
    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx;
    cmd_value = val; cmd_handle = hnd; cmd_is_handle = ish;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic add_res(input logic b, input logic [7:0] v);
    res_tab[res_wr] = {b, v};
    res_wr++;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic accept_rsp(input string tag);
    $display("rsp %s status=%0d bool=%0d value=%02h", tag, rsp_status, rsp_bool, rsp_value);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_rsp_cleared"}, rsp_valid, 0);
  endtask

  initial begin
    int base, n;
    bit seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_index = '0; cmd_value = '0;
    cmd_handle = '0; cmd_is_handle = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_op_start", op_start, 0);
    check_eq("rst_op_selector", op_selector, 0);
    check_eq("rst_op_index", op_index, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_status", rsp_status, 0);
    check_eq("rst_rsp_value", rsp_value, 0);

    // UPDATE idx 3 value 5A, chooser answers after 2 cycles
    base = starts;
    add_res(1'b0, 8'h5A);
    push_cmd(3'd1, 4'd3, 8'h5A, 8'h00, 1'b0);
    wait_rsp("upd", 20);
    check_eq("upd_status", rsp_status, 0);
    check_eq("upd_value", rsp_value, 8'h5A);
    check_eq("upd_starts", starts - base, 1);
    check_eq("upd_sel", sel_log[base], 2);
    check_eq("upd_idx", idx_log[base], 3);
    check_eq("upd_val", val_log[base], 8'h5A);
    accept_rsp("upd");

    // LOOKUP idx 7: scan returns 11 (discarded), finalize returns bool 1 value 42
    base = starts;
    add_res(1'b0, 8'h11);
    add_res(1'b1, 8'h42);
    push_cmd(3'd0, 4'd7, 8'h00, 8'h00, 1'b0);
    wait_rsp("lkp", 30);
    check_eq("lkp_status", rsp_status, 0);
    check_eq("lkp_bool", rsp_bool, 1);
    check_eq("lkp_value", rsp_value, 8'h42);
    check_eq("lkp_starts", starts - base, 2);
    check_eq("lkp_sel0", sel_log[base], 0);
    check_eq("lkp_sel1", sel_log[base+1], 1);
    check_eq("lkp_idx1", idx_log[base+1], 7);
    accept_rsp("lkp");
    repeat (4) tick();
    check_eq("lkp_single_rsp", rsp_valid, 0);

    // illegal opcode 6 followed by ENCODE carrying a handle
    base = starts;
    add_res(1'b1, 8'h77);
    push_cmd(3'd6, 4'd2, 8'h99, 8'h00, 1'b0);
    push_cmd(3'd3, 4'd1, 8'h33, 8'h9C, 1'b1);
    wait_rsp("ill", 10);
    check_eq("ill_status", rsp_status, 1);
    check_eq("ill_value", rsp_value, 0);
    check_eq("ill_bool", rsp_bool, 0);
    check_eq("ill_no_start", starts - base, 0);
    accept_rsp("ill");
    wait_rsp("enc", 20);
    check_eq("enc_status", rsp_status, 0);
    check_eq("enc_value", rsp_value, 8'h77);
    check_eq("enc_bool", rsp_bool, 1);
    check_eq("enc_sel", sel_log[base], 4);
    check_eq("enc_handle", hnd_log[base], 8'h9C);
    check_eq("enc_is_handle", ish_log[base], 1);
    accept_rsp("enc");

    // DELETE with no completion: timeout OP_TIMEOUT cycles after WAIT entry
    chooser_en = 1'b0;
    push_cmd(3'd2, 4'd4, 8'h10, 8'h00, 1'b0);
    n = 0;
    while (op_start !== 1'b1 && n < 10) begin tick(); n++; end
    check_eq("del_start_seen", op_start, 1);
    check_eq("del_sel", op_selector, 3);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check_eq("del_timeout_cycles", n, OP_TIMEOUT + 1);
    check_eq("del_status", rsp_status, 2);
    check_eq("del_value", rsp_value, 0);
    accept_rsp("del");
    chooser_en = 1'b1;

    // five back-to-back UPDATEs against a slow chooser fill the FIFO
    done_delay = 12;
    for (int i = 0; i < 5; i++) begin
      add_res(1'b0, 8'hA0 + 8'(i));
      check_eq($sformatf("fill_ready_%0d", i), cmd_ready, 1);
      push_cmd(3'd1, 4'(i), 8'hA0 + 8'(i), 8'h00, 1'b0);
    end
    check_eq("fill_full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_value = 8'hEE;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("fill%0d", i), 40);
      check_eq($sformatf("fill_value_%0d", i), rsp_value, 8'hA0 + 8'(i));
      check_eq($sformatf("fill_status_%0d", i), rsp_status, 0);
      accept_rsp($sformatf("fill%0d", i));
    end
    seen = 1'b0;
    repeat (30) begin tick(); if (rsp_valid === 1'b1) seen = 1'b1; end
    check_eq("fill_no_extra_rsp", seen, 0);
    done_delay = 2;

    // reset during WAIT2, then a stray op_done
    chooser_en = 1'b0;
    push_cmd(3'd0, 4'd5, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (op_start !== 1'b1 && n < 10) begin tick(); n++; end
    tick();
    manual_res = 9'h011;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    check_eq("rw_fin_start", op_start, 1);
    check_eq("rw_fin_sel", op_selector, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = starts;
    check_eq("rw_op_start", op_start, 0);
    check_eq("rw_op_selector", op_selector, 0);
    check_eq("rw_op_index", op_index, 0);
    check_eq("rw_cmd_ready", cmd_ready, 1);
    check_eq("rw_rsp_valid", rsp_valid, 0);
    manual_res = 9'h1FF;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick(); if (rsp_valid === 1'b1) seen = 1'b1; end
    check_eq("rw_no_rsp", seen, 0);
    check_eq("rw_no_start", starts - base, 0);
    check_eq("rw_rsp_value", rsp_value, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
